// File: rtl/ecg_group_sched_pkg.sv
// Purpose: shared constants and FSM encoding for the ECG group bits scheduler.
// Latency: none (declarations only).
// Backpressure: not applicable.
package ecg_group_sched_pkg;

  localparam int NUM_ECG     = 4;  // ECG groups per block
  localparam int GRP_SAMPLES = 4;  // samples per group
  localparam int BITS_W      = 4;  // width of one bits-required field

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ecg_group_sched_bits.sv
// Purpose: bits-required for one group of four signed samples (ECG 0..2 sign-magnitude, ECG 3 two's complement).
// Latency: purely combinational.
// Backpressure: none; the caller time-multiplexes it.
module ecg_group_sched_bits
  import ecg_group_sched_pkg::*;
#(
  parameter int J = 10  // sample width, 9 or 10
) (
  input  logic [GRP_SAMPLES*J-1:0] samples,
  input  logic [1:0]               ecgidx,
  output logic [BITS_W-1:0]        bits
);

  logic [J-1:0]      acc;
  logic [J-1:0]      smp;
  logic              any_nz;
  logic [BITS_W-1:0] pos;

  // OR-reduce the per-sample width indicators, then locate the highest set bit.
  // For two's complement, a negative sample is folded onto its one's complement
  // so that the highest set bit + 1 yields the minimum signed width.
  always_comb begin
    acc    = '0;
    smp    = '0;
    any_nz = 1'b0;
    pos    = '0;
    bits   = '0;
    for (int k = 0; k < GRP_SAMPLES; k++) begin
      smp    = samples[k*J +: J];
      any_nz = any_nz | (|smp);
      if (ecgidx == 2'd3) acc = acc | (smp ^ {J{smp[J-1]}});
      else                acc = acc | (smp[J-1] ? -smp : smp);
    end
    for (int i = 0; i < J; i++) begin
      if (acc[i]) pos = BITS_W'(i + 1);
    end
    if (ecgidx == 2'd3) bits = any_nz ? pos + 4'd1 : 4'd0;
    else                bits = pos;
  end

endmodule

// File: rtl/ecg_group_sched.sv
// Purpose: accepts a 16-sample block and computes bits-required for 4 ECG groups with one shared unit.
// Latency: result valid 4 edges after acceptance; one block per 6 cycles at best.
// Backpressure: result held in DONE until out_ready; in_ready only asserted in IDLE.
module ecg_group_sched
  import ecg_group_sched_pkg::*;
#(
  parameter int J = 10  // sample width, 9 or 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_ECG*GRP_SAMPLES*J-1:0] in_samples,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_ECG*BITS_W-1:0]       bits_req,
  output logic [7:0]                      total_bits,
  output logic [NUM_ECG-1:0]              size_changed
);

  state_t                            state, state_nxt;
  logic [1:0]                        cnt;
  logic [NUM_ECG*GRP_SAMPLES*J-1:0]  samples_q;
  logic [NUM_ECG*BITS_W-1:0]         prev_size;
  logic [GRP_SAMPLES*J-1:0]          grp;
  logic [BITS_W-1:0]                 calc_bits;
  logic [5:0]                        bits_sum;

  assign grp = samples_q[int'(cnt)*GRP_SAMPLES*J +: GRP_SAMPLES*J];

  // Single bits-required unit, stepped across the groups by cnt.
  ecg_group_sched_bits #(.J(J)) u_bits (
    .samples (grp),
    .ecgidx  (cnt),
    .bits    (calc_bits)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CALC;
      end
      CALC: begin
        if (cnt == 2'd3) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch block on accept, fill one result slot per CALC cycle,
  // remember delivered sizes on the output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 2'd0;
      samples_q <= '0;
      bits_req  <= '0;
      prev_size <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            samples_q <= in_samples;
            cnt       <= 2'd0;
          end
        end
        CALC: begin
          bits_req[int'(cnt)*BITS_W +: BITS_W] <= calc_bits;
          cnt                                  <= cnt + 2'd1;
        end
        DONE: begin
          if (out_ready) prev_size <= bits_req;
        end
        default: ;
      endcase
    end
  end

  // Payload size and per-ECG change flags derived from the stored slots.
  always_comb begin
    bits_sum = 6'({2'b00, bits_req[3:0]}) + 6'({2'b00, bits_req[7:4]})
             + 6'({2'b00, bits_req[11:8]}) + 6'({2'b00, bits_req[15:12]});
    total_bits = {bits_sum, 2'b00};
    for (int g = 0; g < NUM_ECG; g++) begin
      size_changed[g] = bits_req[g*BITS_W +: BITS_W] != prev_size[g*BITS_W +: BITS_W];
    end
  end

endmodule

// File: tb/tb_ecg_group_sched.sv
// Purpose: randomized and directed self-checking bench for ecg_group_sched.
// Latency: checks 4-edge result latency and 6-cycle back-to-back spacing.
// Backpressure: exercises out_ready stalls and in_valid outside IDLE.
module tb_ecg_group_sched;

  localparam int J = 10;
  localparam int W = 16 * J;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_samples;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  bits_req;
  logic [7:0]   total_bits;
  logic [3:0]   size_changed;

  int tests = 0;
  int errs  = 0;
  int prev [4];
  logic [W-1:0] blk;
  logic [W-1:0] q [$];

  ecg_group_sched #(.J(J)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_samples   (in_samples),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .bits_req     (bits_req),
    .total_bits   (total_bits),
    .size_changed (size_changed)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic void put(input int g, input int k, input int v);
    logic [31:0] t;
    t = v;
    blk[(4*g+k)*J +: J] = t[J-1:0];
  endfunction

  function automatic logic [W-1:0] rnd_blk();
    logic [W-1:0]          b;
    logic [31:0]           t;
    logic signed [J-1:0]   sv;
    int                    sh;
    b = '0;
    for (int g = 0; g < 4; g++) begin
      if ($urandom_range(0, 4) == 0) continue;
      for (int k = 0; k < 4; k++) begin
        t  = $urandom;
        sh = $urandom_range(0, J);
        sv = t[J-1:0];
        sv = sv >>> sh;
        b[(4*g+k)*J +: J] = sv;
      end
    end
    return b;
  endfunction

  // Reference: width rules evaluated directly on integer sample values.
  function automatic int ref_bits(input logic [W-1:0] b, input int g);
    logic signed [J-1:0] sv;
    int v, m, n, w, allz;
    w = 0; allz = 1;
    for (int k = 0; k < 4; k++) begin
      sv = b[(4*g+k)*J +: J];
      v  = sv;
      if (v != 0) allz = 0;
      if (g < 3) begin
        m = (v < 0) ? -v : v;
        n = 0;
        while ((1 << n) <= m) n++;
      end else begin
        n = 1;
        while (!(v >= -(1 << (n-1)) && v < (1 << (n-1)))) n++;
      end
      if (n > w) w = n;
    end
    return allz ? 0 : w;
  endfunction

  task automatic model(input logic [W-1:0] b, output logic [15:0] req,
                       output logic [7:0] tot, output logic [3:0] sc);
    int s, r;
    s = 0; req = '0; sc = '0;
    for (int g = 0; g < 4; g++) begin
      r = ref_bits(b, g);
      req[4*g +: 4] = 4'(r);
      sc[g] = (r != prev[g]);
      s += r;
    end
    tot = 8'(4 * s);
  endtask

  task automatic commit(input logic [W-1:0] b);
    for (int g = 0; g < 4; g++) prev[g] = ref_bits(b, g);
  endtask

  task automatic check_outputs(input string tag, input logic [W-1:0] b);
    logic [15:0] req; logic [7:0] tot; logic [3:0] sc;
    model(b, req, tot, sc);
    check({tag, "_bits_req"}, 32'(bits_req), 32'(req));
    check({tag, "_total"}, 32'(total_bits), 32'(tot));
    check({tag, "_changed"}, 32'(size_changed), 32'(sc));
  endtask

  // Offer one block, keep in_valid high with garbage samples while busy,
  // stall the result for 'hold' cycles, then hand it off.
  task automatic run_block(input string tag, input logic [W-1:0] b, input int hold);
    int n;
    logic [15:0] req_s;
    @(negedge clk);
    in_valid = 1'b1; in_samples = b; out_ready = 1'b0;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_samples = rnd_blk() ^ {W{1'b1}};
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); @(negedge clk); n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd4);
    check_outputs(tag, b);
    req_s = bits_req;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      in_samples = rnd_blk();
      check({tag, "_stall_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_stall_stable"}, 32'(bits_req), 32'(req_s));
    end
    if (hold > 0) check_outputs({tag, "_post_stall"}, b);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    check({tag, "_handoff"}, 32'(out_valid), 32'd0);
    commit(b);
  endtask

  initial begin
    int delivered, last_cyc;
    logic [W-1:0] exp_b;
    rst = 1'b1; in_valid = 1'b0; in_samples = '0; out_ready = 1'b0;
    for (int g = 0; g < 4; g++) prev[g] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_bits_req", 32'(bits_req), 32'd0);
    check("rst_total", 32'(total_bits), 32'd0);
    check("rst_changed", 32'(size_changed), 32'd0);

    // group0 = (5,-3,0,0)
    blk = '0; put(0, 0, 5); put(0, 1, -3);
    run_block("g0_small", blk, 0);

    // ECG3 two's complement: -1 then 4
    blk = '0; put(3, 0, -1);
    run_block("ecg3_m1", blk, 0);
    blk = '0; put(3, 0, 4);
    run_block("ecg3_p4", blk, 0);

    // all samples at the most negative value
    blk = '0;
    for (int i = 0; i < 16; i++) put(i / 4, i % 4, -512);
    run_block("all_min", blk, 0);

    // long stall with in_valid held high
    run_block("stall10", rnd_blk(), 10);

    // reset during the second CALC cycle
    blk = rnd_blk(); put(0, 0, 7); put(3, 2, -100);
    @(negedge clk);
    in_valid = 1'b1; in_samples = blk;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int g = 0; g < 4; g++) prev[g] = 0;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_bits_req", 32'(bits_req), 32'd0);
    check("mid_rst_total", 32'(total_bits), 32'd0);
    check("mid_rst_changed", 32'(size_changed), 32'd0);
    run_block("after_rst", blk, 0);

    // randomized blocks with random stalls
    for (int r = 0; r < 20; r++) run_block("rnd", rnd_blk(), $urandom_range(0, 3));

    // back-to-back with in_valid and out_ready tied high
    delivered = 0; last_cyc = -1;
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && delivered < 8; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (out_valid) begin
        if (q.size() == 0) begin
          check("b2b_unexpected_result", 32'd1, 32'd0);
        end else begin
          exp_b = q.pop_front();
          check_outputs("b2b", exp_b);
          commit(exp_b);
        end
        if (last_cyc >= 0) check("b2b_interval", 32'(cyc - last_cyc), 32'd6);
        last_cyc = cyc;
        delivered++;
      end
      if (delivered < 8 && in_ready) begin
        blk = rnd_blk();
        in_samples = blk;
        q.push_back(blk);
      end else begin
        in_samples = rnd_blk();
      end
    end
    in_valid = 1'b0;
    check("b2b_delivered", 32'(delivered), 32'd8);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b_idle", 32'(in_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
